// File: rtl/gpio_pkg.sv
// Shared GPIO types and constants for the input-conditioning path.
// Debounce counter width is derived here so every pin agrees on it.
package gpio_pkg;

  localparam int unsigned GPIO_WIDTH = 32;
  localparam int unsigned GPIO_DEB_DEFAULT = 16;

  typedef logic [GPIO_WIDTH-1:0] gpio_vec_t;

  function automatic int unsigned deb_cnt_width(
    input int unsigned deb
  );
    return $clog2(deb + 1);
  endfunction

endpackage

// File: rtl/gpio_in_bit.sv
// One GPIO pin: two-flop synchroniser, optional debounce, edge pulses.
// level_o changes only after the synchronised pad holds DEB_CYCLES cycles.
module gpio_in_bit
  import gpio_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = GPIO_DEB_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pad_i,
  input  logic deb_en_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = deb_cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          s1_d, s1_q;
  logic          s2_d, s2_q;
  logic          level_d, level_q;
  logic          level_dly_d, level_dly_q;
  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    s1_d        = pad_i;
    s2_d        = s1_q;
    level_d     = level_q;
    level_dly_d = level_q;
    cnt_d       = '0;
    if (!deb_en_i) begin
      level_d = s2_q;
    end else if (s2_q != level_q) begin
      // Terminal count accepts the new level; counter restarts at 0.
      if (cnt_q == CNT_LAST) begin
        level_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      level_q     <= level_d;
      level_dly_q <= level_dly_d;
      cnt_q       <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = level_q & ~level_dly_q;
  assign fall_o  = ~level_q & level_dly_q;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioning: per-pin sync/debounce/edges plus W1C pending.
// Pending bits and irq_o exist only when GPIO_IN_IRQ_EN is defined.
module gpio_in_cond
  import gpio_pkg::*;
#(
  parameter int unsigned WIDTH      = GPIO_WIDTH,
  parameter int unsigned DEB_CYCLES = GPIO_DEB_DEFAULT
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] pad_i,
  input  logic [WIDTH-1:0] oe_i,
  input  logic [WIDTH-1:0] deb_en_i,
  input  logic [WIDTH-1:0] rise_en_i,
  input  logic [WIDTH-1:0] fall_en_i,
  input  logic [WIDTH-1:0] irq_clr_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] irq_pend_o,
  output logic             irq_o
);

  for (genvar n = 0; n < WIDTH; n++) begin : g_pin
    gpio_in_bit #(
      .DEB_CYCLES (DEB_CYCLES)
    ) u_bit (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .pad_i    (pad_i[n]),
      .deb_en_i (deb_en_i[n]),
      .level_o  (level_o[n]),
      .rise_o   (rise_o[n]),
      .fall_o   (fall_o[n])
    );
  end

`ifdef GPIO_IN_IRQ_EN
  logic [WIDTH-1:0] set_w;
  logic [WIDTH-1:0] pend_d, pend_q;

  // Set has priority over a same-cycle clear.
  always_comb begin
    set_w  = ~oe_i & ((rise_o & rise_en_i) | (fall_o & fall_en_i));
    pend_d = (pend_q & ~irq_clr_i) | set_w;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign irq_pend_o = pend_q;
  assign irq_o      = |pend_q;
`else
  logic unused_irq_in;

  assign unused_irq_in = ^{oe_i, rise_en_i, fall_en_i, irq_clr_i};
  assign irq_pend_o    = '0;
  assign irq_o         = 1'b0;
`endif

endmodule

// File: tb/tb_gpio_in_cond.sv
// Directed bench for gpio_in_cond (WIDTH=32, DEB_CYCLES=16).
// Pending expectations follow whether GPIO_IN_IRQ_EN is built in.
module tb_gpio_in_cond;
  import gpio_pkg::*;

`ifdef GPIO_IN_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic      clk_i = 1'b0;
  logic      reset_i;
  gpio_vec_t pad_i, oe_i, deb_en_i;
  gpio_vec_t rise_en_i, fall_en_i, irq_clr_i;
  gpio_vec_t level_o, rise_o, fall_o, irq_pend_o;
  logic      irq_o;

  int vecs = 0;
  int errs = 0;

  always #5 clk_i = ~clk_i;

  gpio_in_cond #(
    .WIDTH      (32),
    .DEB_CYCLES (16)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .pad_i      (pad_i),
    .oe_i       (oe_i),
    .deb_en_i   (deb_en_i),
    .rise_en_i  (rise_en_i),
    .fall_en_i  (fall_en_i),
    .irq_clr_i  (irq_clr_i),
    .level_o    (level_o),
    .rise_o     (rise_o),
    .fall_o     (fall_o),
    .irq_pend_o (irq_pend_o),
    .irq_o      (irq_o)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] lvl,
                         input logic [31:0] ri, input logic [31:0] fa,
                         input logic [31:0] pe);
    chk({tag, ".level"}, level_o, lvl);
    chk({tag, ".rise"}, rise_o, ri);
    chk({tag, ".fall"}, fall_o, fa);
    chk({tag, ".pend"}, irq_pend_o, IRQ ? pe : 32'h0);
    chk({tag, ".irq"}, {31'h0, irq_o}, {31'h0, IRQ && (pe != 0)});
  endtask

  initial begin
    reset_i   = 1'b1;
    pad_i     = '0;
    oe_i      = '0;
    deb_en_i  = '0;
    rise_en_i = '0;
    fall_en_i = '0;
    irq_clr_i = '0;
    tick(3);
    chk_all("reset", 32'h0, 32'h0, 32'h0, 32'h0);
    reset_i = 1'b0;
    tick(10);

    // No debounce: three edges from pad to level
    pad_i[0] = 1'b1;
    tick(2);
    chk_all("nodeb_e2", 32'h0, 32'h0, 32'h0, 32'h0);
    tick(1);
    chk_all("nodeb_e3", 32'h1, 32'h1, 32'h0, 32'h0);
    tick(1);
    chk_all("nodeb_e4", 32'h1, 32'h0, 32'h0, 32'h0);

    // Debounce: 15-cycle glitch rejected
    deb_en_i[3] = 1'b1;
    pad_i[3] = 1'b1;
    tick(15);
    pad_i[3] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk("glitch_rise3", {31'h0, rise_o[3]}, 32'h0);
    end
    chk("glitch_level", level_o, 32'h1);

    // Debounce: 16-cycle hold accepted at edge 18
    pad_i[3] = 1'b1;
    tick(17);
    chk_all("deb_e17", 32'h1, 32'h0, 32'h0, 32'h0);
    tick(1);
    chk_all("deb_e18", 32'h9, 32'h8, 32'h0, 32'h0);
    tick(1);
    chk_all("deb_e19", 32'h9, 32'h0, 32'h0, 32'h0);

    // Rising-edge interrupt, then write-1-to-clear
    rise_en_i[5] = 1'b1;
    pad_i[5] = 1'b1;
    tick(3);
    chk_all("irq_rise", 32'h29, 32'h20, 32'h0, 32'h0);
    tick(1);
    chk_all("irq_pend", 32'h29, 32'h0, 32'h0, 32'h20);
    irq_clr_i[5] = 1'b1;
    tick(1);
    irq_clr_i[5] = 1'b0;
    chk_all("irq_clr", 32'h29, 32'h0, 32'h0, 32'h0);

    // Falling edge with same-cycle clear: set wins
    fall_en_i[7] = 1'b1;
    pad_i[7] = 1'b1;
    tick(5);
    chk_all("p7_high", 32'hA9, 32'h0, 32'h0, 32'h0);
    pad_i[7] = 1'b0;
    tick(3);
    chk_all("p7_fall", 32'h29, 32'h0, 32'h80, 32'h0);
    irq_clr_i[7] = 1'b1;
    tick(1);
    irq_clr_i[7] = 1'b0;
    chk_all("setwins", 32'h29, 32'h0, 32'h0, 32'h80);
    irq_clr_i = 32'h8000_0001;
    tick(1);
    irq_clr_i = '0;
    chk_all("clr_zero", 32'h29, 32'h0, 32'h0, 32'h80);
    irq_clr_i[7] = 1'b1;
    tick(1);
    irq_clr_i[7] = 1'b0;
    chk_all("clr7", 32'h29, 32'h0, 32'h0, 32'h0);

    // Output-enabled pin: edge pulses, no pending
    oe_i[2] = 1'b1;
    rise_en_i[2] = 1'b1;
    pad_i[2] = 1'b1;
    tick(3);
    chk_all("oe_rise", 32'h2D, 32'h4, 32'h0, 32'h0);
    tick(1);
    chk_all("oe_mask", 32'h2D, 32'h0, 32'h0, 32'h0);

    // Reset 8 cycles into a debounce count
    deb_en_i[4] = 1'b1;
    pad_i[4] = 1'b1;
    tick(8);
    chk("pre_rst_level", level_o, 32'h2D);
    reset_i = 1'b1;
    #1;
    chk_all("rst_async", 32'h0, 32'h0, 32'h0, 32'h0);
    tick(2);
    chk_all("rst_hold", 32'h0, 32'h0, 32'h0, 32'h0);
    reset_i = 1'b0;
    tick(3);
    chk_all("rel_e3", 32'h25, 32'h25, 32'h0, 32'h0);
    tick(1);
    chk_all("rel_e4", 32'h25, 32'h0, 32'h0, 32'h20);
    tick(13);
    chk_all("rel_e17", 32'h25, 32'h0, 32'h0, 32'h20);
    tick(1);
    chk_all("rel_e18", 32'h3D, 32'h18, 32'h0, 32'h20);
    tick(1);
    chk_all("rel_e19", 32'h3D, 32'h0, 32'h0, 32'h20);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
